// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer between a CPU request port and a 1536x8 RAM.
// Define MEMSEQ_CHECK_EN to reject misaligned and out-of-range requests.
module mem_byte_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [10:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        RAM_RE,
  output logic [10:0] RAM_RADDR,
  input  logic [7:0]  RAM_RDATA,
  output logic        RAM_WE,
  output logic [10:0] RAM_WADDR,
  output logic [7:0]  RAM_WDATA
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [11:0] LP_LAST_ADDR = 12'd1535;

  function automatic logic [1:0] f_last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] last,
                                           input logic uns);
    case (last)
      2'd0:    return uns ? {24'd0, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'd1:    return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [10:0] r_addr, w_addr_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        r_uns, w_uns_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_err, w_err_nxt;

  logic        r_ram_re, w_ram_re_nxt;
  logic [10:0] r_raddr, w_raddr_nxt;
  logic        r_ram_we, w_ram_we_nxt;
  logic [10:0] r_waddr, w_waddr_nxt;
  logic [7:0]  r_ram_wdata, w_ram_wdata_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;

  logic [1:0]  w_acc_last;
  logic [10:0] w_acc_addr;
  logic        w_acc_err;

  // Decode the incoming request: byte count, effective address and rejection.
  always_comb begin
    w_acc_last = f_last_idx(req_size);
`ifdef MEMSEQ_CHECK_EN
    w_acc_addr = req_addr;
    w_acc_err  = ((w_acc_last == 2'd1) && req_addr[0]) ||
                 ((w_acc_last == 2'd3) && (req_addr[1:0] != 2'b00)) ||
                 (({1'b0, req_addr} + {10'd0, w_acc_last}) > LP_LAST_ADDR);
`else
    case (w_acc_last)
      2'd1:    w_acc_addr = {req_addr[10:1], 1'b0};
      2'd3:    w_acc_addr = {req_addr[10:2], 2'b00};
      default: w_acc_addr = req_addr;
    endcase
    w_acc_err = 1'b0;
`endif
  end

  // Next-state and next-value logic for the sequencer and its registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_uns_nxt   = r_uns;
    w_wdata_nxt = r_wdata;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_we_nxt    = req_we;
          w_addr_nxt  = w_acc_addr;
          w_last_nxt  = w_acc_last;
          w_idx_nxt   = 2'd0;
          w_uns_nxt   = req_unsigned;
          w_wdata_nxt = req_wdata;
          w_data_nxt  = 32'd0;
          w_err_nxt   = w_acc_err;
          if (w_acc_err) begin
            w_state_nxt = RESP;
          end else if (req_we) begin
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD_ADDR;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_ADDR: w_state_nxt = RD_CAP;
      RD_CAP: begin
        case (r_idx)
          2'd0:    w_data_nxt[7:0]   = RAM_RDATA;
          2'd1:    w_data_nxt[15:8]  = RAM_RDATA;
          2'd2:    w_data_nxt[23:16] = RAM_RDATA;
          default: w_data_nxt[31:24] = RAM_RDATA;
        endcase
        if (r_idx == r_last) begin
          w_state_nxt = RESP;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = RD_ADDR;
        end
      end
      WR: begin
        if (r_idx == r_last) begin
          w_state_nxt = RESP;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = WR;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered
    // without adding a cycle of latency.
    w_ram_re_nxt = (w_state_nxt == RD_ADDR) || (w_state_nxt == RD_CAP);
    w_ram_we_nxt = (w_state_nxt == WR);
    if (w_ram_re_nxt) begin
      w_raddr_nxt = w_addr_nxt + {9'd0, w_idx_nxt};
    end else begin
      w_raddr_nxt = r_raddr;
    end
    if (w_ram_we_nxt) begin
      w_waddr_nxt     = w_addr_nxt + {9'd0, w_idx_nxt};
      w_ram_wdata_nxt = f_byte(w_wdata_nxt, w_idx_nxt);
    end else begin
      w_waddr_nxt     = r_waddr;
      w_ram_wdata_nxt = r_ram_wdata;
    end
    w_rsp_valid_nxt = (w_state_nxt == RESP);
    if (w_state_nxt == RESP) begin
      w_rsp_rdata_nxt = (w_we_nxt || w_err_nxt) ? 32'd0
                        : f_extend(w_data_nxt, w_last_nxt, w_uns_nxt);
      w_rsp_err_nxt   = w_err_nxt;
    end else begin
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 11'd0;
      r_last      <= 2'd0;
      r_idx       <= 2'd0;
      r_uns       <= 1'b0;
      r_wdata     <= 32'd0;
      r_data      <= 32'd0;
      r_err       <= 1'b0;
      r_ram_re    <= 1'b0;
      r_raddr     <= 11'd0;
      r_ram_we    <= 1'b0;
      r_waddr     <= 11'd0;
      r_ram_wdata <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_last      <= w_last_nxt;
      r_idx       <= w_idx_nxt;
      r_uns       <= w_uns_nxt;
      r_wdata     <= w_wdata_nxt;
      r_data      <= w_data_nxt;
      r_err       <= w_err_nxt;
      r_ram_re    <= w_ram_re_nxt;
      r_raddr     <= w_raddr_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Ready must drop the moment reset asserts, hence the direct RST_N term.
  assign req_ready = (r_state == IDLE) && RST_N;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign RAM_RE    = r_ram_re;
  assign RAM_RADDR = r_raddr;
  assign RAM_WE    = r_ram_we;
  assign RAM_WADDR = r_waddr;
  assign RAM_WDATA = r_ram_wdata;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed self-checking bench for mem_byte_seq with a behavioural 1536x8 RAM.
module tb_mem_byte_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [10:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        RAM_RE, RAM_WE;
  logic [10:0] RAM_RADDR, RAM_WADDR;
  logic [7:0]  RAM_RDATA, RAM_WDATA;

  int n_tests = 0;
  int n_fail  = 0;

  mem_byte_seq dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .RAM_RE(RAM_RE), .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA),
    .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA)
  );

  always #5 CLK = ~CLK;

  // RAM model: registered read of an even/odd pair, output mux on current address.
  logic [7:0] mem [0:1535] = '{default: 8'h00};
  logic [7:0] rd_p0 = 8'h00;
  logic [7:0] rd_p1 = 8'h00;
  int cyc_cnt = 0, re_cnt = 0, we_cnt = 0, stab_err = 0, overlap_err = 0;
  int acc_n = 0, last_acc = 0, last_gap = 0;
  logic       re_phase = 1'b0;
  logic [10:0] prev_raddr = 11'd0;

  function automatic logic [7:0] rd_at(input logic [10:0] a);
    return (a < 11'd1536) ? mem[a] : 8'h00;
  endfunction

  assign RAM_RDATA = RAM_RADDR[0] ? rd_p1 : rd_p0;

  always @(posedge CLK) begin
    cyc_cnt = cyc_cnt + 1;
    if (RAM_WE && (RAM_WADDR < 11'd1536)) mem[RAM_WADDR] = RAM_WDATA;
    if (RAM_WE) we_cnt = we_cnt + 1;
    if (RAM_RE && RAM_WE) overlap_err = overlap_err + 1;
    if (RAM_RE) begin
      re_cnt = re_cnt + 1;
      rd_p0 <= rd_at({RAM_RADDR[10:1], 1'b0});
      rd_p1 <= rd_at({RAM_RADDR[10:1], 1'b1});
      if (re_phase && (RAM_RADDR != prev_raddr)) stab_err = stab_err + 1;
      re_phase   = ~re_phase;
      prev_raddr = RAM_RADDR;
    end else begin
      re_phase = 1'b0;
    end
    if (req_valid && req_ready) begin
      if (acc_n > 0) last_gap = cyc_cnt - last_acc;
      last_acc = cyc_cnt;
      acc_n    = acc_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [10:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int k;
    @(negedge CLK);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    @(posedge CLK);
    #1;
    // Scramble inputs after acceptance: the DUT must use its latched copy.
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_size = ~size;
    req_unsigned = ~uns; req_wdata = ~wd;
    lat = 1;
    @(negedge CLK);
    while (!rsp_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic run(input string tag, input logic we, input logic [10:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    logic [31:0] rd;
    logic er;
    do_req(we, addr, size, uns, wd, lat, rd, er);
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".rdata"}, rd, exp_rd);
    check_eq({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, k, rv, acc_before;
    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 11'd0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
    repeat (3) @(negedge CLK);
    check_eq("rst.ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst.rdata", rsp_rdata, 32'd0);
    check_eq("rst.ram_en", {30'd0, RAM_RE, RAM_WE}, 32'd0);
    check_eq("rst.ram_addr", {10'd0, RAM_RADDR, RAM_WADDR}, 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("idle.ready", {31'd0, req_ready}, 32'd1);
    check_eq("idle.no_access", re_cnt + we_cnt, 32'd0);

    run("st_w4", 1'b1, 11'h004, 2'b10, 1'b0, 32'hDEADBEEF, 5, 32'd0, 1'b0);
    check_eq("st_w4.mem", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);
    run("ld_w4", 1'b0, 11'h004, 2'b10, 1'b0, 32'd0, 9, 32'hDEADBEEF, 1'b0);
    repeat (3) @(negedge CLK);
    check_eq("rdata_hold", rsp_rdata, 32'hDEADBEEF);

    run("st_b1ff", 1'b1, 11'h1FF, 2'b00, 1'b0, 32'h00000080, 2, 32'd0, 1'b0);
    run("ld_b_s", 1'b0, 11'h1FF, 2'b00, 1'b0, 32'd0, 3, 32'hFFFFFF80, 1'b0);
    run("ld_b_u", 1'b0, 11'h1FF, 2'b00, 1'b1, 32'd0, 3, 32'h00000080, 1'b0);
    run("st_b1fe", 1'b1, 11'h1FE, 2'b00, 1'b0, 32'h00000034, 2, 32'd0, 1'b0);
    run("ld_h1fe", 1'b0, 11'h1FE, 2'b01, 1'b0, 32'd0, 5, 32'hFFFF8034, 1'b0);
    run("st_w3fc", 1'b1, 11'h3FC, 2'b10, 1'b0, 32'h44332211, 5, 32'd0, 1'b0);
    check_eq("st_w3fc.mem", {mem[11'h3FF], mem[11'h3FE], mem[11'h3FD], mem[11'h3FC]},
             32'h44332211);
    run("ld_w3fc", 1'b0, 11'h3FC, 2'b10, 1'b0, 32'd0, 9, 32'h44332211, 1'b0);
    run("st_h10", 1'b1, 11'h010, 2'b01, 1'b0, 32'h1234A5C3, 3, 32'd0, 1'b0);
    run("st_b12", 1'b1, 11'h012, 2'b00, 1'b0, 32'hFFFFFF7F, 2, 32'd0, 1'b0);
    run("ld_w10", 1'b0, 11'h010, 2'b10, 1'b1, 32'd0, 9, 32'h007FA5C3, 1'b0);
    run("ld_h10_u", 1'b0, 11'h010, 2'b01, 1'b1, 32'd0, 5, 32'h0000A5C3, 1'b0);
    run("ld_sz3", 1'b0, 11'h004, 2'b11, 1'b0, 32'd0, 9, 32'hDEADBEEF, 1'b0);

`ifdef MEMSEQ_CHECK_EN
    acc_before = re_cnt + we_cnt;
    run("err_mis", 1'b0, 11'h002, 2'b10, 1'b0, 32'd0, 1, 32'd0, 1'b1);
    run("err_oor", 1'b1, 11'h600, 2'b10, 1'b0, 32'h11111111, 1, 32'd0, 1'b1);
    check_eq("err.no_access", re_cnt + we_cnt, acc_before);
`else
    run("align_w6", 1'b0, 11'h006, 2'b10, 1'b0, 32'd0, 9, 32'hDEADBEEF, 1'b0);
    run("oor_w600", 1'b0, 11'h600, 2'b10, 1'b0, 32'd0, 9, 32'd0, 1'b0);
`endif

    // Reset in the second cycle of a word store.
    @(negedge CLK);
    req_we = 1'b1; req_addr = 11'h020; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = 32'h11223344; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check_eq("mid_rst.we", {31'd0, RAM_WE}, 32'd0);
    check_eq("mid_rst.ready", {31'd0, req_ready}, 32'd0);
    check_eq("mid_rst.waddr", {21'd0, RAM_WADDR}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp_valid) rv++;
    end
    check_eq("mid_rst.no_rsp", rv, 32'd0);
    check_eq("mid_rst.ready_after", {31'd0, req_ready}, 32'd1);
    check_eq("mid_rst.mem", {16'd0, mem[11'h021], mem[11'h020]}, 32'h00000044);

    // Back-to-back byte stores with req_valid held high.
    @(negedge CLK);
    req_we = 1'b1; req_addr = 11'h030; req_size = 2'b00; req_unsigned = 1'b0;
    req_wdata = 32'h0000009A; req_valid = 1'b1;
    acc0 = acc_n;
    k = 0;
    while (acc_n < acc0 + 3 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    req_valid = 1'b0;
    check_eq("b2b.count", acc_n - acc0, 32'd3);
    check_eq("b2b.gap", last_gap, 32'd3);
    repeat (4) @(negedge CLK);
    check_eq("b2b.mem", {24'd0, mem[11'h030]}, 32'h0000009A);

    check_eq("raddr_stable", stab_err, 32'd0);
    check_eq("no_overlap", overlap_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
